// File: rtl/fix_msg_framer.sv
// fix_msg_framer
//   Byte-stream front end that finds FIX message boundaries and writes them
//   to the message-location store. A message starts at "8=" (BeginString)
//   and ends at the SOH closing the "<SOH>10=...<SOH>" CheckSum field.
//   Each message produces one store_start_o strobe followed by one
//   store_end_o strobe at the same addr_o, after which addr_o advances.
//
// Ports
//   clk           : clock, all logic on rising edge
//   rst           : asynchronous active-low reset
//   data_i        : stream byte
//   valid_i       : data_i valid (always accepted)
//   clear_i       : synchronous clear of addr_o/full_o/FSM (position kept)
//   start_o       : offset of the '8' opening the current message
//   end_o         : offset of the SOH closing the checksum field
//   store_start_o : 1-cycle write strobe for start_o
//   store_end_o   : 1-cycle write strobe for end_o
//   addr_o        : binary slot index for both strobes
//   full_o        : sticky, all NUM_MESSAGE slots written
//   len_err_o     : 1-cycle pulse, message aborted on length overflow
module fix_msg_framer #(
  parameter int unsigned DATA_WIDTH  = 5,
  parameter int unsigned NUM_MESSAGE = 10,
  parameter logic [7:0]  SOH         = 8'h01
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             data_i,
  input  logic                   valid_i,
  input  logic                   clear_i,
  output logic [DATA_WIDTH-1:0]  start_o,
  output logic [DATA_WIDTH-1:0]  end_o,
  output logic                   store_start_o,
  output logic                   store_end_o,
  output logic [NUM_MESSAGE-1:0] addr_o,
  output logic                   full_o,
  output logic                   len_err_o
);

  localparam logic [7:0] CH_8  = 8'h38;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_0  = 8'h30;

  localparam logic [DATA_WIDTH-1:0]  LEN_MAX   = '1;
  localparam logic [NUM_MESSAGE-1:0] ADDR_LAST = NUM_MESSAGE'(NUM_MESSAGE - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_S8,
    ST_BODY,
    ST_T1,
    ST_T0,
    ST_CKS
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [DATA_WIDTH-1:0]   r_pos;
  logic [DATA_WIDTH-1:0]   r_cand;
  logic [DATA_WIDTH-1:0]   r_len;
  logic [DATA_WIDTH-1:0]   w_len_nxt;
  logic                    r_field_start;
  logic [DATA_WIDTH-1:0]   r_start;
  logic [DATA_WIDTH-1:0]   r_end;
  logic                    r_store_start;
  logic                    r_store_end;
  logic [NUM_MESSAGE-1:0]  r_addr;
  logic                    r_full;
  logic                    r_len_err;
  logic                    w_set_start;
  logic                    w_set_end;
  logic                    w_len_err;
  logic                    w_cand_ld;
  logic                    w_full_eff;
  logic                    w_is_soh;

  assign w_is_soh = (data_i == SOH);

  // The last slot's store_end strobe sets full_o one cycle late; a '8'
  // arriving during that strobe must already see the store as full.
  assign w_full_eff = r_full | (r_store_end & (r_addr == ADDR_LAST));

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len;
    w_set_start = 1'b0;
    w_set_end   = 1'b0;
    w_len_err   = 1'b0;
    w_cand_ld   = 1'b0;
    if (valid_i && !clear_i) begin
      unique case (r_state)
        ST_IDLE: begin
          if (data_i == CH_8 && !w_full_eff) begin
            w_state_nxt = ST_S8;
            w_cand_ld   = 1'b1;
            w_len_nxt   = DATA_WIDTH'(1);
          end
        end
        ST_S8: begin
          if (data_i == CH_EQ) begin
            w_state_nxt = ST_BODY;
            w_set_start = 1'b1;
            w_len_nxt   = DATA_WIDTH'(2);
          end else if (data_i == CH_8) begin
            w_cand_ld   = 1'b1;
            w_len_nxt   = DATA_WIDTH'(1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: begin
          // Any further byte at maximum length overflows, closing SOH included.
          if (r_len == LEN_MAX) begin
            w_len_err   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_len_nxt = r_len + DATA_WIDTH'(1);
            unique case (r_state)
              ST_BODY: if (data_i == CH_1 && r_field_start) w_state_nxt = ST_T1;
              ST_T1:   w_state_nxt = (data_i == CH_0)  ? ST_T0  : ST_BODY;
              ST_T0:   w_state_nxt = (data_i == CH_EQ) ? ST_CKS : ST_BODY;
              ST_CKS: begin
                if (w_is_soh) begin
                  w_state_nxt = ST_IDLE;
                  w_set_end   = 1'b1;
                end
              end
              default: w_state_nxt = ST_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else if (clear_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos         <= '0;
      r_cand        <= '0;
      r_len         <= '0;
      r_field_start <= 1'b1;
      r_start       <= '0;
      r_end         <= '0;
      r_store_start <= 1'b0;
      r_store_end   <= 1'b0;
      r_addr        <= '0;
      r_full        <= 1'b0;
      r_len_err     <= 1'b0;
    end else begin
      // Position advances on every accepted byte, even one dropped by clear.
      if (valid_i) r_pos <= r_pos + DATA_WIDTH'(1);
      r_store_start <= 1'b0;
      r_store_end   <= 1'b0;
      r_len_err     <= 1'b0;
      if (clear_i) begin
        r_addr <= '0;
        r_full <= 1'b0;
      end else begin
        if (valid_i) r_field_start <= w_is_soh;
        if (w_cand_ld) r_cand <= r_pos;
        r_len         <= w_len_nxt;
        r_store_start <= w_set_start;
        r_store_end   <= w_set_end;
        r_len_err     <= w_len_err;
        if (w_set_start) r_start <= r_cand;
        if (w_set_end)   r_end   <= r_pos;
        if (r_store_end) begin
          if (r_addr == ADDR_LAST) r_full <= 1'b1;
          else                     r_addr <= r_addr + NUM_MESSAGE'(1);
        end
      end
    end
  end

  assign start_o       = r_start;
  assign end_o         = r_end;
  assign store_start_o = r_store_start;
  assign store_end_o   = r_store_end;
  assign addr_o        = r_addr;
  assign full_o        = r_full;
  assign len_err_o     = r_len_err;

endmodule
